// File: rtl/age_ordered_issue_queue.sv
// Age-ordered issue queue: holds renamed uops, wakes sources from the CDBs and issues the
// oldest ready uop (by ROB distance from head) into a registered valid/ready output stage.
module age_ordered_issue_queue #(
    parameter int DEPTH     = 8,
    parameter int PREG_W    = 6,
    parameter int ROB_W     = 5,
    parameter int PAYLOAD_W = 64,
    parameter int NUM_CDB   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [ROB_W-1:0]            rob_head,
    input  logic                        disp_valid,
    output logic                        disp_ready,
    input  logic [PREG_W-1:0]           disp_ps1,
    input  logic [PREG_W-1:0]           disp_ps2,
    input  logic                        disp_ps1_v,
    input  logic                        disp_ps2_v,
    input  logic [ROB_W-1:0]            disp_rob_idx,
    input  logic [PAYLOAD_W-1:0]        disp_payload,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*PREG_W-1:0]   cdb_pd,
    output logic                        iss_valid,
    input  logic                        iss_ready,
    output logic [PREG_W-1:0]           iss_ps1,
    output logic [PREG_W-1:0]           iss_ps2,
    output logic [ROB_W-1:0]            iss_rob_idx,
    output logic [PAYLOAD_W-1:0]        iss_payload,
    output logic [$clog2(DEPTH+1)-1:0]  count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);

    logic [DEPTH-1:0]     slot_valid, rdy1, rdy2, wake1, wake2;
    logic [PREG_W-1:0]    ps1_q [DEPTH];
    logic [PREG_W-1:0]    ps2_q [DEPTH];
    logic [ROB_W-1:0]     rob_q [DEPTH];
    logic [PAYLOAD_W-1:0] pay_q [DEPTH];
    logic [ROB_W-1:0]     age   [DEPTH];

    logic [IW-1:0]    free_idx, sel_idx;
    logic             sel_found;
    logic [ROB_W-1:0] best_age;
    logic             disp_r1, disp_r2, disp_fire, issue_load;

    // Tag 0 never matches a broadcast; it is handled as always-ready separately.
    function automatic logic woken(input logic [PREG_W-1:0] tag,
                                   input logic [NUM_CDB-1:0] v,
                                   input logic [NUM_CDB*PREG_W-1:0] pd);
        woken = 1'b0;
        for (int k = 0; k < NUM_CDB; k++)
            if (v[k] && tag != '0 && pd[k*PREG_W +: PREG_W] == tag)
                woken = 1'b1;
    endfunction

    always_comb begin
        wake1 = '0;
        wake2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wake1[i] = woken(ps1_q[i], cdb_valid, cdb_pd);
            wake2[i] = woken(ps2_q[i], cdb_valid, cdb_pd);
            age[i]   = rob_q[i] - rob_head;
        end
    end

    assign disp_r1    = disp_ps1_v || disp_ps1 == '0 || woken(disp_ps1, cdb_valid, cdb_pd);
    assign disp_r2    = disp_ps2_v || disp_ps2 == '0 || woken(disp_ps2, cdb_valid, cdb_pd);
    assign disp_ready = count < CW'(DEPTH);
    assign disp_fire  = disp_valid && disp_ready;

    // Descending scan so the lowest free index is the last one written.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--)
            if (!slot_valid[i])
                free_idx = IW'(i);
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        best_age  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i] && rdy1[i] && rdy2[i] && (!sel_found || age[i] < best_age)) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
                best_age  = age[i];
            end
        end
    end

    assign issue_load = (!iss_valid || iss_ready) && sel_found;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid  <= '0;
            rdy1        <= '0;
            rdy2        <= '0;
            count       <= '0;
            iss_valid   <= 1'b0;
            iss_ps1     <= '0;
            iss_ps2     <= '0;
            iss_rob_idx <= '0;
            iss_payload <= '0;
        end else if (flush) begin
            slot_valid <= '0;
            count      <= '0;
            iss_valid  <= 1'b0;
        end else begin
            rdy1 <= rdy1 | wake1;
            rdy2 <= rdy2 | wake2;
            if (issue_load) begin
                slot_valid[sel_idx] <= 1'b0;
                iss_valid           <= 1'b1;
                iss_ps1             <= ps1_q[sel_idx];
                iss_ps2             <= ps2_q[sel_idx];
                iss_rob_idx         <= rob_q[sel_idx];
                iss_payload         <= pay_q[sel_idx];
            end else if (iss_ready) begin
                iss_valid <= 1'b0;
            end
            // free_idx is never the selected slot, so these writes cannot collide.
            if (disp_fire) begin
                slot_valid[free_idx] <= 1'b1;
                rdy1[free_idx]       <= disp_r1;
                rdy2[free_idx]       <= disp_r2;
            end
            case ({disp_fire, issue_load})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && disp_fire) begin
            ps1_q[free_idx] <= disp_ps1;
            ps2_q[free_idx] <= disp_ps2;
            rob_q[free_idx] <= disp_rob_idx;
            pay_q[free_idx] <= disp_payload;
        end
    end
endmodule

// File: tb/tb_age_ordered_issue_queue.sv
// Directed scenarios followed by random traffic, all checked against an unordered-queue model
// of the issue queue that selects by modular ROB age.
module tb_age_ordered_issue_queue;
    logic        clk = 1'b0;
    logic        rst, flush;
    logic [4:0]  rob_head;
    logic        disp_valid, disp_ready;
    logic [5:0]  disp_ps1, disp_ps2;
    logic        disp_ps1_v, disp_ps2_v;
    logic [4:0]  disp_rob_idx;
    logic [63:0] disp_payload;
    logic [1:0]  cdb_valid;
    logic [11:0] cdb_pd;
    logic        iss_valid, iss_ready;
    logic [5:0]  iss_ps1, iss_ps2;
    logic [4:0]  iss_rob_idx;
    logic [63:0] iss_payload;
    logic [3:0]  count;

    age_ordered_issue_queue dut (
        .clk(clk), .rst(rst), .flush(flush), .rob_head(rob_head),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_ps1(disp_ps1), .disp_ps2(disp_ps2),
        .disp_ps1_v(disp_ps1_v), .disp_ps2_v(disp_ps2_v),
        .disp_rob_idx(disp_rob_idx), .disp_payload(disp_payload),
        .cdb_valid(cdb_valid), .cdb_pd(cdb_pd),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_ps1(iss_ps1), .iss_ps2(iss_ps2),
        .iss_rob_idx(iss_rob_idx), .iss_payload(iss_payload),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  ps1;
        logic [5:0]  ps2;
        bit          r1;
        bit          r2;
        logic [4:0]  rob;
        logic [63:0] pay;
        int          seq;
    } ent_t;

    ent_t q[$];
    ent_t m_iss;
    bit   m_iv;
    int   next_seq = 0;
    int   passes = 0;
    int   total = 0;

    function automatic bit cdb_hit(input logic [5:0] tag);
        return tag != 0 && ((cdb_valid[0] && cdb_pd[5:0] == tag) ||
                            (cdb_valid[1] && cdb_pd[11:6] == tag));
    endfunction

    function automatic logic [4:0] age_of(input logic [4:0] r);
        return r - rob_head;
    endfunction

    // Advance the model across one clock edge using the inputs currently driven.
    task automatic model_edge();
        int   win;
        bit   do_disp;
        ent_t ne;
        if (rst || flush) begin
            q.delete();
            m_iv = 0;
            if (rst) begin
                m_iss.ps1 = 0; m_iss.ps2 = 0; m_iss.rob = 0; m_iss.pay = 0;
            end
        end else begin
            win = -1;
            for (int i = 0; i < q.size(); i++)
                if (q[i].r1 && q[i].r2 && (win < 0 || age_of(q[i].rob) < age_of(q[win].rob)))
                    win = i;
            do_disp = disp_valid && q.size() < 8;
            if (do_disp) begin
                ne.ps1 = disp_ps1; ne.ps2 = disp_ps2;
                ne.r1  = disp_ps1_v || disp_ps1 == 0 || cdb_hit(disp_ps1);
                ne.r2  = disp_ps2_v || disp_ps2 == 0 || cdb_hit(disp_ps2);
                ne.rob = disp_rob_idx; ne.pay = disp_payload; ne.seq = next_seq;
            end
            if ((!m_iv || iss_ready) && win >= 0) begin
                m_iss = q[win];
                m_iv  = 1;
                q.delete(win);
            end else if (iss_ready) begin
                m_iv = 0;
            end
            for (int i = 0; i < q.size(); i++) begin
                if (cdb_hit(q[i].ps1)) q[i].r1 = 1;
                if (cdb_hit(q[i].ps2)) q[i].r2 = 1;
            end
            if (do_disp) begin
                q.push_back(ne);
                next_seq++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("disp_ready", {63'd0, disp_ready}, {63'd0, q.size() < 8});
        chk("count", {60'd0, count}, 64'(q.size()));
        chk("iss_valid", {63'd0, iss_valid}, {63'd0, m_iv});
        if (m_iv) begin
            chk("iss_rob_idx", {59'd0, iss_rob_idx}, {59'd0, m_iss.rob});
            chk("iss_ps1", {58'd0, iss_ps1}, {58'd0, m_iss.ps1});
            chk("iss_ps2", {58'd0, iss_ps2}, {58'd0, m_iss.ps2});
            chk("iss_payload", iss_payload, m_iss.pay);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        flush = 0; disp_valid = 0; disp_ps1 = 0; disp_ps2 = 0;
        disp_ps1_v = 0; disp_ps2_v = 0; disp_rob_idx = 0; disp_payload = 0;
        cdb_valid = 0; cdb_pd = 0;
    endtask

    task automatic disp(input logic [4:0] rob, input logic [5:0] p1, input bit v1,
                        input logic [5:0] p2, input bit v2);
        disp_valid = 1; disp_rob_idx = rob;
        disp_ps1 = p1; disp_ps1_v = v1; disp_ps2 = p2; disp_ps2_v = v2;
        disp_payload = {$urandom, $urandom};
    endtask

    initial begin
        int oldest;
        rst = 1; rob_head = 0; iss_ready = 0;
        idle();
        @(negedge clk);
        step();
        chk("reset_iss_rob_idx", {59'd0, iss_rob_idx}, 64'd0);
        chk("reset_iss_payload", iss_payload, 64'd0);
        rst = 0;

        // T1: single ready uop appears two cycles after dispatch
        disp(5'd3, 6'd0, 0, 6'd0, 0);
        step();
        idle(); iss_ready = 1;
        chk("t1_not_yet", {63'd0, iss_valid}, 64'd0);
        step();
        chk("t1_iss_valid", {63'd0, iss_valid}, 64'd1);
        chk("t1_rob", {59'd0, iss_rob_idx}, 64'd3);
        chk("t1_count", {60'd0, count}, 64'd0);
        step();

        // T2: three waiters on p9 woken by port 1 issue in ROB order
        iss_ready = 0;
        for (int i = 5; i <= 7; i++) begin
            disp(5'(i), 6'd9, 0, 6'd0, 0);
            step();
        end
        idle(); cdb_valid = 2'b10; cdb_pd = {6'd9, 6'd0};
        step();
        idle(); iss_ready = 1;
        step();
        for (int i = 5; i <= 7; i++) begin
            chk("t2_order", {59'd0, iss_rob_idx}, 64'(i));
            step();
        end

        // T3: ROB wrap, head=30: rob 31 is older than rob 0
        iss_ready = 0; rob_head = 5'd30;
        disp(5'd0, 6'd5, 0, 6'd0, 0);  step();
        disp(5'd31, 6'd5, 0, 6'd0, 0); step();
        idle(); cdb_valid = 2'b01; cdb_pd = {6'd0, 6'd5};
        step();
        idle(); iss_ready = 1;
        step();
        chk("t3_first", {59'd0, iss_rob_idx}, 64'd31);
        step();
        chk("t3_second", {59'd0, iss_rob_idx}, 64'd0);
        step();

        // T4: fill the queue behind a stalled output stage
        iss_ready = 0; rob_head = 0;
        for (int i = 0; i < 9; i++) begin
            disp(5'(i), 6'd0, 0, 6'd0, 1);
            step();
        end
        idle();
        chk("t4_full_ready", {63'd0, disp_ready}, 64'd0);
        chk("t4_full_count", {60'd0, count}, 64'd8);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_stable", {59'd0, iss_rob_idx}, 64'd0);
        end
        iss_ready = 1;
        step();
        chk("t4_count_after", {60'd0, count}, 64'd7);
        for (int i = 0; i < 10; i++) step();

        // T5: wakeup in the dispatch cycle itself
        disp(5'd9, 6'd12, 0, 6'd0, 0);
        cdb_valid = 2'b01; cdb_pd = {6'd0, 6'd12};
        step();
        idle();
        step();
        chk("t5_issue", {63'd0, iss_valid}, 64'd1);
        chk("t5_rob", {59'd0, iss_rob_idx}, 64'd9);
        step();

        // T6: flush with queue occupied and output held, dispatch dropped
        iss_ready = 0;
        disp(5'd10, 6'd0, 1, 6'd0, 1); step();
        for (int i = 0; i < 5; i++) begin
            disp(5'(11 + i), 6'd20, 0, 6'd0, 1);
            step();
        end
        flush = 1; disp(5'd16, 6'd0, 1, 6'd0, 1);
        step();
        chk("t6_count", {60'd0, count}, 64'd0);
        chk("t6_iss_valid", {63'd0, iss_valid}, 64'd0);
        idle();

        // Random traffic; head tracks the oldest uop still in flight
        next_seq = 20;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            oldest = next_seq;
            foreach (q[i]) if (q[i].seq < oldest) oldest = q[i].seq;
            if (m_iv && m_iss.seq < oldest) oldest = m_iss.seq;
            rob_head = oldest[4:0];
            flush = ($urandom_range(0, 99) < 2);
            iss_ready = ($urandom_range(0, 9) < 7);
            disp_valid = (next_seq - oldest < 28) && ($urandom_range(0, 9) < 6);
            disp_rob_idx = next_seq[4:0];
            disp_ps1 = 6'($urandom_range(0, 15));
            disp_ps2 = 6'($urandom_range(0, 15));
            disp_ps1_v = ($urandom_range(0, 3) == 0);
            disp_ps2_v = ($urandom_range(0, 3) == 0);
            disp_payload = {$urandom, $urandom};
            cdb_valid = 2'($urandom_range(0, 3));
            cdb_pd = {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15))};
            step();
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
